// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the CPU control blocks.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    REDIRECT,
    HALTED
  } hazard_state_t;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stalls, freezes and flushes for load-use,
// memory wait, redirect and halt, plus a saturating stall-cycle counter.
//
// state      | meaning
// RUN        | normal flow, load-use detection active
// LOAD_STALL | one bubble inserted for a load-use; detection suppressed
// MEM_WAIT   | data memory not ready; IF/ID and ID/EX held
// REDIRECT   | pipeline just flushed; detection suppressed for a cycle
// HALTED     | halt reached writeback; only reset leaves
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmem_req,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_wdest,
  input  logic        redirect,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_freeze,
  output logic        idex_freeze,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halt,
  output logic [31:0] stall_count
);

  hazard_state_t state, next_state;
  logic [31:0]   stall_cnt;
  regbits_t      rs, rt, wdest;
  logic          mem_wait, load_use;

  assign rs    = ifid_rs;
  assign rt    = ifid_rt;
  assign wdest = idex_wdest;

  assign mem_wait = dmem_req & ~dhit;
  assign load_use = idex_memread && (wdest != '0) && ((wdest == rs) || (wdest == rt));

  assign stall_count = stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (!pc_en && (state != HALTED) && (stall_cnt != STALL_MAX))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    ifid_freeze = 1'b0;
    idex_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halt        = 1'b0;
    if (RST) begin
      next_state = RUN;
    end else if ((state == HALTED) || wb_halt) begin
      next_state  = HALTED;
      halt        = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_wait) begin
      // a pending redirect is simply held here until the data side completes
      next_state  = MEM_WAIT;
      ifid_freeze = 1'b1;
      idex_freeze = 1'b1;
    end else if (redirect) begin
      next_state  = REDIRECT;
      pc_en       = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use && (state == RUN)) begin
      next_state  = LOAD_STALL;
      ifid_freeze = 1'b1;
      idex_flush  = 1'b1;
    end else begin
      next_state = RUN;
      pc_en      = ihit;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, dmem_req = 1'b0;
  logic [4:0]  ifid_rs = '0, ifid_rt = '0, idex_wdest = '0;
  logic        idex_memread = 1'b0, redirect = 1'b0, wb_halt = 1'b0;
  logic        pc_en, ifid_freeze, idex_freeze, ifid_flush, idex_flush, exmem_flush, halt;
  logic [31:0] stall_count;
  logic [6:0]  obs;

  int checks = 0;
  int errors = 0;

  // model state: halted flag, "previous cycle was not a plain run cycle", counter
  bit          m_halted, m_no_lu;
  logic [31:0] m_count;
  logic [6:0]  e_out;
  bit          e_plain;

  localparam logic [6:0] O_HALT  = 7'b0001111;
  localparam logic [6:0] O_MWAIT = 7'b0110000;
  localparam logic [6:0] O_REDIR = 7'b1001110;
  localparam logic [6:0] O_LU    = 7'b0100100;
  localparam logic [6:0] O_GO    = 7'b1000000;

  hazard_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_memread(idex_memread),
    .idex_wdest(idex_wdest), .redirect(redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_freeze(ifid_freeze), .idex_freeze(idex_freeze),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halt(halt), .stall_count(stall_count)
  );

  assign obs = {pc_en, ifid_freeze, idex_freeze, ifid_flush, idex_flush, exmem_flush, halt};

  always #5 CLK = ~CLK;

  function automatic void model_eval();
    bit hazard;
    hazard  = idex_memread && (idex_wdest != 0) &&
              (idex_wdest == ifid_rs || idex_wdest == ifid_rt);
    e_plain = 1'b0;
    if (RST)                       e_out = 7'b0;
    else if (m_halted || wb_halt)  e_out = O_HALT;
    else if (dmem_req && !dhit)    e_out = O_MWAIT;
    else if (redirect)             e_out = O_REDIR;
    else if (hazard && !m_no_lu)   e_out = O_LU;
    else begin
      e_out   = {ihit, 6'b0};
      e_plain = 1'b1;
    end
  endfunction

  function automatic void model_update();
    if (RST) return;
    if (!m_halted && !e_out[6] && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    if (wb_halt) m_halted = 1'b1;
    m_no_lu = !e_plain;
  endfunction

  task automatic apply(input bit ih, input bit dr, input bit dh, input logic [4:0] rs,
                       input logic [4:0] rt, input bit mr, input logic [4:0] wd,
                       input bit rd, input bit wh);
    ihit = ih; dmem_req = dr; dhit = dh; ifid_rs = rs; ifid_rt = rt;
    idex_memread = mr; idex_wdest = wd; redirect = rd; wb_halt = wh;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    m_halted = 1'b0; m_no_lu = 1'b0; m_count = '0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    apply(1, 0, 1, 5'd3, 5'd4, 1, 5'd3, 1, 0);
    @(posedge CLK); @(negedge CLK); #1;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0); end
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    apply(1, 0, 0, 5'd5, 5'd0, 1, 5'd5, 0, 0);
    checks++;
    if (obs !== O_LU) begin errors++; $display("FAIL load_use_stall: got %b expected %b", obs, O_LU); end
    tick();
    apply(1, 0, 0, 5'd5, 5'd0, 1, 5'd5, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL load_use_no_retrigger: got %b expected %b", obs, O_GO); end
    checks++;
    if (stall_count !== 32'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count); end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    apply(1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL zero_reg_out: got %b expected %b", obs, O_GO); end
    tick();
    apply(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL zero_reg_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
      checks++;
      if (obs !== O_MWAIT) begin errors++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, obs, O_MWAIT); end
      tick();
    end
    apply(1, 1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL mem_wait_release: got %b expected %b", obs, O_GO); end
    checks++;
    if (stall_count !== 32'd3) begin errors++; $display("FAIL mem_wait_count: got %0d expected 3", stall_count); end
    tick();
    apply(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL mem_wait_run: got %b expected %b", obs, O_GO); end
    tick();
  endtask

  task automatic test_redirect_in_wait();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0);
      checks++;
      if (obs !== O_MWAIT) begin errors++; $display("FAIL redir_wait_hold[%0d]: got %b expected %b", i, obs, O_MWAIT); end
      tick();
    end
    apply(1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0);
    checks++;
    if (obs !== O_REDIR) begin errors++; $display("FAIL redir_wait_service: got %b expected %b", obs, O_REDIR); end
    tick();
    apply(1, 0, 0, 5'd7, 5'd0, 1, 5'd7, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL redir_suppress_lu: got %b expected %b", obs, O_GO); end
    tick();
    apply(1, 0, 0, 5'd7, 5'd0, 1, 5'd7, 0, 0);
    checks++;
    if (obs !== O_LU) begin errors++; $display("FAIL redir_then_lu: got %b expected %b", obs, O_LU); end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    apply(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    checks++;
    if (obs !== e_out) begin errors++; $display("FAIL halt_entry: got %b expected %b", obs, e_out); end
    tick();
    for (int i = 0; i < 5; i++) begin
      apply($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom_range(0, 1), 0);
      checks++;
      if (obs !== O_HALT) begin errors++; $display("FAIL halt_sticky[%0d]: got %b expected %b", i, obs, O_HALT); end
      checks++;
      if (stall_count !== m_count) begin errors++; $display("FAIL halt_count_frozen[%0d]: got %0d expected %0d", i, stall_count, m_count); end
      tick();
    end
    do_reset();
    apply(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    checks++;
    if (halt !== 1'b0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL halt_cleared: got halt=%b count=%0d expected halt=0 count=0", halt, stall_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    apply(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL async_reset: got out=%b count=%0d expected out=0 count=0", obs, stall_count);
    end
    m_halted = 1'b0; m_no_lu = 1'b0; m_count = '0;
    @(negedge CLK);
    RST = 1'b0;
    apply(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    checks++;
    if (obs !== O_GO) begin errors++; $display("FAIL async_reset_run: got %b expected %b", obs, O_GO); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    dut.stall_cnt = 32'hFFFF_FFFE;
    m_count = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      tick();
    end
    apply(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    checks++;
    if (stall_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL saturation: got %h expected ffffffff", stall_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, 0);
      checks++;
      if (obs !== e_out) begin errors++; $display("FAIL random_out[%0d]: got %b expected %b", i, obs, e_out); end
      checks++;
      if (stall_count !== m_count) begin errors++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, stall_count, m_count); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_redirect_in_wait();
    test_halt();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
